// File: rtl/brick_field_sequencer_pkg.sv
// Shared types and brick-field geometry for the sequencer and the collision logic.
package brick_field_sequencer_pkg;
  localparam int COORD_W = 10;

  localparam int DEF_ROWS      = 4;
  localparam int DEF_COLS      = 8;
  localparam int DEF_GO_CYCLES = 2;

  localparam logic [COORD_W-1:0] DEF_X0      = 10'd8;
  localparam logic [COORD_W-1:0] DEF_Y0      = 10'd16;
  localparam logic [COORD_W-1:0] DEF_BRICK_W = 10'd16;
  localparam logic [COORD_W-1:0] DEF_BRICK_H = 10'd6;
  localparam logic [COORD_W-1:0] DEF_GAP     = 10'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_GO_HI,
    S_WAIT_START,
    S_WAIT_END,
    S_ADVANCE,
    S_DONE
  } state_t;
endpackage

// File: rtl/brick_field_sequencer_if.sv
// Game-logic and rectangle-drawer side signals of the brick field sequencer.
interface brick_field_sequencer_if
  import brick_field_sequencer_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
);
  logic                 start;
  logic [ROWS*COLS-1:0] brick_alive;
  logic                 drw_wren;
  logic                 go;
  logic [COORD_W-1:0]   x_out;
  logic [COORD_W-1:0]   y_out;
  logic [COORD_W-1:0]   width;
  logic [COORD_W-1:0]   height;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, brick_alive, drw_wren,
    output go, x_out, y_out, width, height, busy, done
  );

  modport slave (
    output start, brick_alive, drw_wren,
    input  go, x_out, y_out, width, height, busy, done
  );
endinterface

// File: rtl/brick_field_sequencer_draw_done.sv
// Detects the end of one drawn rectangle: two consecutive wren-low cycles after any high.
module brick_draw_done_detect
  import brick_field_sequencer_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic arm,
  input  logic drw_wren,
  output logic rect_done
);
  logic seen_high;
  // One bit is enough: the second low cycle is flagged combinationally.
  logic low_once;

  always_ff @(posedge clk) begin
    if (!resetn || !arm) begin
      seen_high <= 1'b0;
      low_once  <= 1'b0;
    end else if (drw_wren) begin
      seen_high <= 1'b1;
      low_once  <= 1'b0;
    end else if (seen_high) begin
      low_once  <= 1'b1;
    end
  end

  assign rect_done = arm & seen_high & ~drw_wren & low_once;
endmodule

// File: rtl/brick_field_sequencer.sv
// Walks the brick-alive bitmap row-major and hands each live brick to the rectangle drawer.
module brick_field_sequencer
  import brick_field_sequencer_pkg::*;
#(
  parameter int                 ROWS      = DEF_ROWS,
  parameter int                 COLS      = DEF_COLS,
  parameter logic [COORD_W-1:0] X0        = DEF_X0,
  parameter logic [COORD_W-1:0] Y0        = DEF_Y0,
  parameter logic [COORD_W-1:0] BRICK_W   = DEF_BRICK_W,
  parameter logic [COORD_W-1:0] BRICK_H   = DEF_BRICK_H,
  parameter logic [COORD_W-1:0] GAP       = DEF_GAP,
  parameter int                 GO_CYCLES = DEF_GO_CYCLES
) (
  input logic                     clk,
  input logic                     resetn,
  brick_field_sequencer_if.master bus
);
  localparam int NB    = ROWS * COLS;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int GC_W  = (GO_CYCLES > 1) ? $clog2(GO_CYCLES) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NB - 1);
  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(COLS - 1);
  localparam logic [GC_W-1:0]    GC_LAST  = GC_W'(GO_CYCLES - 1);
  localparam logic [COORD_W-1:0] COL_STEP = BRICK_W + GAP;
  localparam logic [COORD_W-1:0] ROW_STEP = BRICK_H + GAP;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [COL_W-1:0]   col;
  logic [GC_W-1:0]    go_cnt;
  logic [COORD_W-1:0] x_q, y_q;
  logic               go_q, busy_q, done_q;
  logic               rect_done;

  brick_draw_done_detect u_done_detect (
    .clk       (clk),
    .resetn    (resetn),
    .arm       ((state == S_WAIT_START) || (state == S_WAIT_END)),
    .drw_wren  (bus.drw_wren),
    .rect_done (rect_done)
  );

  // Coordinates only move in IDLE and ADVANCE, so they hold for the whole draw.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      idx    <= '0;
      col    <= '0;
      go_cnt <= '0;
      x_q    <= X0;
      y_q    <= Y0;
      go_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= S_CHECK;
            idx    <= '0;
            col    <= '0;
            x_q    <= X0;
            y_q    <= Y0;
            busy_q <= 1'b1;
          end
        end
        S_CHECK: begin
          if (bus.brick_alive[idx]) begin
            state  <= S_GO_HI;
            go_q   <= 1'b1;
            go_cnt <= '0;
          end else begin
            state  <= S_ADVANCE;
          end
        end
        S_GO_HI: begin
          if (go_cnt == GC_LAST) begin
            go_q  <= 1'b0;
            state <= S_WAIT_START;
          end else begin
            go_cnt <= go_cnt + 1'b1;
          end
        end
        S_WAIT_START: if (bus.drw_wren) state <= S_WAIT_END;
        S_WAIT_END:   if (rect_done)    state <= S_ADVANCE;
        S_ADVANCE: begin
          if (col == COL_LAST) begin
            col <= '0;
            x_q <= X0;
            y_q <= y_q + ROW_STEP;
          end else begin
            col <= col + 1'b1;
            x_q <= x_q + COL_STEP;
          end
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state  <= S_DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state  <= S_CHECK;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.go     = go_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.x_out  = x_q;
  assign bus.y_out  = y_q;
  assign bus.width  = BRICK_W;
  assign bus.height = BRICK_H;
endmodule

// File: tb/tb_brick_field_sequencer.sv
// Brick field sequencer bench: behavioural drawer plus a list-of-bricks reference model.
module tb_brick_field_sequencer;
  localparam int ROWS = 4, COLS = 8, NB = ROWS * COLS, GO_CYCLES = 2;
  localparam int X0 = 8, Y0 = 16, BW = 16, BH = 6, GAP = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  brick_field_sequencer_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
  brick_field_sequencer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vec = 0, miss = 0;
  int got_x[$], got_y[$];
  int col_gap = 0;
  int dphase, dcnt, drow, dcol, dtail, burst, cur_x, cur_y;
  logic prev_go;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Drawer model: starts two cycles after go falls, paints BW columns of BH pixels,
  // optionally with a one-cycle wren gap between columns; also records each go burst.
  initial begin
    bus.drw_wren = 1'b0;
    dphase = 0; dtail = 0; burst = 0; prev_go = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        dphase = 0; dtail = 0; burst = 0; prev_go = 1'b0;
        bus.drw_wren = 1'b0;
      end else begin
        if (dphase >= 2 || dtail > 0) begin
          chk("x_hold", bus.x_out, cur_x);
          chk("y_hold", bus.y_out, cur_y);
        end
        if (dtail > 0) dtail--;
        case (dphase)
          1: begin
            dcnt++;
            if (dcnt == 2) begin
              dphase = 2; drow = 0; dcol = 0;
              bus.drw_wren = 1'b1;
            end
          end
          2: begin
            drow++;
            if (drow == BH) begin
              drow = 0;
              dcol++;
              if (dcol == BW) begin
                bus.drw_wren = 1'b0; dphase = 0; dtail = 2;
              end else if (col_gap != 0) begin
                bus.drw_wren = 1'b0; dphase = 3;
              end
            end
          end
          3: begin
            bus.drw_wren = 1'b1; dphase = 2;
          end
          default: ;
        endcase
        if (bus.go && !prev_go) begin
          chk("go_while_drawing", dphase + dtail, 0);
          got_x.push_back(int'(bus.x_out));
          got_y.push_back(int'(bus.y_out));
          chk("width", bus.width, BW);
          chk("height", bus.height, BH);
          cur_x = int'(bus.x_out); cur_y = int'(bus.y_out);
          burst = 1;
        end else if (bus.go) begin
          burst++;
        end
        if (!bus.go && prev_go) begin
          chk("go_len", burst, GO_CYCLES);
          dphase = 1; dcnt = 0;
        end
        prev_go = bus.go;
      end
    end
  end

  // One full pass: pulse start, optionally re-pulse start or kill brick (3,7) mid-pass,
  // then compare the recorded go bursts with the bricks the model says must be drawn.
  task automatic run_pass(input logic [NB-1:0] alive, input int restart_at, input bit kill37,
                          output int cycles);
    logic [NB-1:0] a;
    int ex_x[$], ex_y[$];
    int dones, extra;
    a = alive;
    bus.brick_alive = a;
    got_x.delete(); got_y.delete();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cycles = 1; dones = 0;
    while (cycles < 20000) begin
      if (bus.done) begin dones++; break; end
      chk("busy_in_pass", bus.busy, 1);
      if (kill37 && got_y.size() > 0 && got_y[got_y.size()-1] == Y0 + 2 * (BH + GAP)) begin
        a[NB-1] = 1'b0;
        bus.brick_alive = a;
      end
      bus.start = (cycles == restart_at);
      @(negedge clk); cycles++;
    end
    bus.start = 1'b0;
    chk("done_seen", dones, 1);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (a[r * COLS + c]) begin
          ex_x.push_back(X0 + c * (BW + GAP));
          ex_y.push_back(Y0 + r * (BH + GAP));
        end
    chk("n_rects", got_x.size(), ex_x.size());
    for (int i = 0; i < got_x.size() && i < ex_x.size(); i++) begin
      chk("rect_x", got_x[i], ex_x[i]);
      chk("rect_y", got_y[i], ex_y[i]);
    end
    @(negedge clk);
    chk("done_pulse_width", bus.done, 0);
    chk("busy_after_done", bus.busy, 0);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done || bus.go || bus.busy) extra++;
    end
    chk("quiet_after_done", extra, 0);
  endtask

  initial begin
    int cyc, waited;
    bus.start = 1'b0;
    bus.brick_alive = '0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_go", bus.go, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_x", bus.x_out, X0);
    chk("rst_y", bus.y_out, Y0);
    chk("rst_w", bus.width, BW);
    chk("rst_h", bus.height, BH);
    resetn = 1'b1;

    // Full field.
    run_pass('1, -1, 1'b0, cyc);
    if (got_x.size() == NB) begin
      chk("first_x", got_x[0], 8);   chk("first_y", got_y[0], 16);
      chk("second_x", got_x[1], 26); chk("second_y", got_y[1], 16);
      chk("ninth_x", got_x[8], 8);   chk("ninth_y", got_y[8], 24);
      chk("last_x", got_x[NB-1], 134); chk("last_y", got_y[NB-1], 40);
    end

    // Empty field: pure scan latency.
    run_pass('0, -1, 1'b0, cyc);
    chk("dead_latency", cyc, 2 * NB + 1);

    // Single brick (1,2).
    run_pass(32'h0000_0400, -1, 1'b0, cyc);
    if (got_x.size() == 1) begin
      chk("solo_x", got_x[0], 44);
      chk("solo_y", got_y[0], 24);
    end

    // Random fields, with and without the inter-column wren gap.
    col_gap = 1;
    repeat (3) run_pass(NB'($urandom), -1, 1'b0, cyc);
    col_gap = 0;
    repeat (2) run_pass(NB'($urandom), -1, 1'b0, cyc);

    // Start re-pulsed mid-pass and brick (3,7) killed once row 2 is being drawn.
    col_gap = 1;
    run_pass('1, 300, 1'b1, cyc);
    col_gap = 0;

    // Reset while the 5th brick is being drawn.
    bus.brick_alive = '1;
    got_x.delete(); got_y.delete();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    waited = 0;
    while (!(got_x.size() == 5 && dphase == 2) && waited < 5000) begin
      @(negedge clk); waited++;
    end
    chk("reach_5th_brick", (waited < 5000) ? 1 : 0, 1);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_go", bus.go, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_x", bus.x_out, X0);
    chk("mid_rst_y", bus.y_out, Y0);
    @(negedge clk);
    resetn = 1'b1;
    run_pass('1, -1, 1'b0, cyc);
    if (got_x.size() > 0) begin
      chk("restart_x", got_x[0], X0);
      chk("restart_y", got_y[0], Y0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
